// File: rtl/dispatch_ex_queue.sv
// Dispatch-to-EX group queue: circular buffer of LANES-wide issue groups.
// Each lane keeps its own valid/payload slice; pointers and count are shared.

module dispatch_ex_lane #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    wr_ptr,
    input  logic [PW-1:0]    rd_ptr,
    input  logic             nonempty,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    // Storage is left unreset; outputs are gated while the queue is empty.
    logic [DEPTH-1:0] v_mem;
    logic [WIDTH-1:0] d_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            v_mem[wr_ptr] <= in_valid;
            d_mem[wr_ptr] <= in_data;
        end
    end

    assign out_valid = nonempty & v_mem[rd_ptr];
    assign out_data  = nonempty ? d_mem[rd_ptr] : '0;
endmodule

module dispatch_ex_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*WIDTH-1:0]     in_data,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*WIDTH-1:0]     out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          nonempty, enq, deq;

    assign nonempty = (count != '0);
    // in_ready depends only on held state, never on out_ready.
    assign in_ready = (count < FULL);
    assign enq      = in_ready && (|in_valid) && !flush;
    assign deq      = nonempty && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dispatch_ex_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_lane (
            .clk       (clk),
            .we        (enq),
            .wr_ptr    (wr_ptr),
            .rd_ptr    (rd_ptr),
            .nonempty  (nonempty),
            .in_valid  (in_valid[i]),
            .in_data   (in_data[i*WIDTH +: WIDTH]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_dispatch_ex_queue.sv
// Directed plus randomized bench for dispatch_ex_queue against a queue-based
// reference model of held groups.

module tb_dispatch_ex_queue;
    localparam int L = 2;
    localparam int D = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst, flush, in_ready, out_ready;
    logic [L-1:0]   in_valid, out_valid;
    logic [L*W-1:0] in_data, out_data;
    logic [2:0]     count;

    dispatch_ex_queue #(.LANES(L), .DEPTH(D), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [L-1:0] m; logic [L*W-1:0] d; } grp_t;
    grp_t  q[$];
    int    errors = 0;
    int    checks = 0;
    string ph = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", ph, tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare after.
    task automatic step(input logic r, input logic f, input logic [L-1:0] iv,
                        input logic [L*W-1:0] id, input logic ordy);
        bit e, d;
        grp_t g;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        @(posedge clk);
        if (r || f) q.delete();
        else begin
            e = (q.size() < D) && (iv != '0);
            d = (q.size() != 0) && ordy;
            if (d) void'(q.pop_front());
            if (e) begin g.m = iv; g.d = id; q.push_back(g); end
        end
        #1;
        chk("count",    32'(count),     32'(q.size()));
        chk("in_ready", 32'(in_ready),  32'(q.size() < D));
        chk("out_valid",32'(out_valid), q.size() != 0 ? 32'(q[0].m) : 32'd0);
        chk("out_data", 32'(out_data),  q.size() != 0 ? 32'(q[0].d) : 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

        ph = "reset";
        step(1, 0, 2'b11, 16'hFFFF, 1);
        step(1, 1, 2'b11, 16'hFFFF, 1);
        chk("c_rst", 32'(count), 0);
        chk("r_rst", 32'(in_ready), 1);

        ph = "first";
        step(0, 0, 2'b11, 16'hB2A1, 0);
        chk("c1", 32'(out_data), 32'h B2A1);
        chk("c2", 32'(count), 1);
        step(1, 0, 2'b00, 0, 0);

        ph = "full";
        for (int i = 1; i <= 5; i++) step(0, 0, 2'b11, 16'(i * 16'h0101), 0);
        chk("c4", 32'(count), 4);
        chk("nrdy", 32'(in_ready), 0);
        chk("head", 32'(out_data), 32'h0101);
        for (int i = 2; i <= 4; i++) begin
            step(0, 0, 2'b00, 0, 1);
            chk("order", 32'(out_data), 32'(i * 16'h0101));
        end
        step(0, 0, 2'b00, 0, 1);
        chk("drained", 32'(out_valid), 0);

        ph = "concur";
        step(0, 0, 2'b11, 16'h1111, 0);
        step(0, 0, 2'b11, 16'h2222, 0);
        step(0, 0, 2'b11, 16'h3333, 1);
        chk("c2", 32'(count), 2);
        chk("head", 32'(out_data), 32'h2222);

        ph = "flush";
        step(0, 0, 2'b01, 16'h4444, 0);
        step(0, 1, 2'b11, 16'h5555, 1);
        chk("c0", 32'(count), 0);
        chk("od0", 32'(out_data), 0);

        ph = "bubble";
        step(0, 0, 2'b00, 16'h9999, 0);
        chk("c0", 32'(count), 0);
        step(0, 0, 2'b10, 16'h7700, 0);
        chk("mask", 32'(out_valid), 32'h2);
        chk("data", 32'(out_data), 32'h7700);
        step(0, 0, 2'b00, 0, 1);

        ph = "stream";
        for (int i = 0; i < 10; i++) step(0, 0, 2'b11, 16'(16'hA000 + i), 1'((i + 1) % 2));
        for (int i = 0; i < 12; i++) step(0, 0, 2'b00, 0, 1);
        chk("empty", 32'(count), 0);

        ph = "random";
        for (int i = 0; i < 400; i++)
            step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                 L'($urandom), (L*W)'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
